// File: rtl/rtc_bus_sequencer.sv
// Round-robin owner of the multiplexed RTC bus: address phase then data phase per transaction.
// Grant to done takes 2*(T_SETUP+T_STROBE+T_HOLD) cycles; a requester holds req until its done pulse.
module rtc_bus_sequencer #(
   parameter int unsigned T_SETUP   = 1,
   parameter int unsigned T_STROBE  = 4,
   parameter int unsigned T_HOLD    = 1,
   parameter int unsigned T_RECOVER = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic [2:0]  req_we,
   input  logic [23:0] req_addr,
   input  logic [23:0] req_wdata,
   output logic [2:0]  gnt,
   output logic [2:0]  done,
   output logic [7:0]  rdata,
   output logic        busy,
   inout  wire  [7:0]  DATA_ADDRESS,
   output logic        ChipSelect,
   output logic        Read,
   output logic        Write,
   output logic        AoD
);

   typedef enum logic [2:0] {
      IDLE, A_SETUP, A_STRB, A_HOLD, D_SETUP, D_STRB, D_HOLD, RECOVER
   } state_t;

   localparam logic [7:0] LD_SETUP   = 8'(T_SETUP - 1);
   localparam logic [7:0] LD_STROBE  = 8'(T_STROBE - 1);
   localparam logic [7:0] LD_HOLD    = 8'(T_HOLD - 1);
   localparam logic [7:0] LD_RECOVER = 8'(T_RECOVER - 1);

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [1:0]  last, sel, cur;
   logic        we_q;
   logic [7:0]  addr_q, wdata_q, rd_shadow;
   logic        addr_phase, data_phase, drive_en;
   logic [7:0]  bus_dat;

   // Search order starts just after the last winner, so the last winner is checked last.
   always_comb begin
      sel = 2'd0;
      case (last)
         2'd0:    sel = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
         2'd1:    sel = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
         default: sel = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (state == IDLE) begin
         if (|req) begin
            state_nxt = A_SETUP;
            cnt_nxt   = LD_SETUP;
         end
      end else if (cnt != 8'd0) begin
         cnt_nxt = cnt - 8'd1;
      end else begin
         case (state)
            A_SETUP: begin state_nxt = A_STRB;  cnt_nxt = LD_STROBE;  end
            A_STRB:  begin state_nxt = A_HOLD;  cnt_nxt = LD_HOLD;    end
            A_HOLD:  begin state_nxt = D_SETUP; cnt_nxt = LD_SETUP;   end
            D_SETUP: begin state_nxt = D_STRB;  cnt_nxt = LD_STROBE;  end
            D_STRB:  begin state_nxt = D_HOLD;  cnt_nxt = LD_HOLD;    end
            D_HOLD:  begin state_nxt = RECOVER; cnt_nxt = LD_RECOVER; end
            default: begin state_nxt = IDLE;    cnt_nxt = 8'd0;       end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         last      <= 2'd2;
         cur       <= 2'd0;
         gnt       <= 3'b000;
         done      <= 3'b000;
         rdata     <= 8'h00;
         we_q      <= 1'b0;
         addr_q    <= 8'h00;
         wdata_q   <= 8'h00;
         rd_shadow <= 8'h00;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         done  <= 3'b000;
         if (state == IDLE && |req) begin
            gnt     <= 3'b001 << sel;
            last    <= sel;
            cur     <= sel;
            we_q    <= req_we[sel];
            addr_q  <= req_addr[8*sel +: 8];
            wdata_q <= req_wdata[8*sel +: 8];
         end
         if (state == D_STRB && cnt == 8'd0 && !we_q)
            rd_shadow <= DATA_ADDRESS;
         // Leaving D_HOLD: done, gnt release and rdata all land on the first RECOVER cycle.
         if (state == D_HOLD && cnt == 8'd0) begin
            gnt  <= 3'b000;
            done <= 3'b001 << cur;
            if (!we_q)
               rdata <= rd_shadow;
         end
      end
   end

   always_comb begin
      addr_phase = (state == A_SETUP) || (state == A_STRB) || (state == A_HOLD);
      data_phase = (state == D_SETUP) || (state == D_STRB) || (state == D_HOLD);
      drive_en   = addr_phase || (data_phase && we_q);
      bus_dat    = addr_phase ? addr_q : wdata_q;
      ChipSelect = !(addr_phase || data_phase);
      AoD        = !addr_phase;
      Write      = !((state == A_STRB) || (state == D_STRB && we_q));
      Read       = !(state == D_STRB && !we_q);
      busy       = (state != IDLE);
   end

   assign DATA_ADDRESS = drive_en ? bus_dat : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: expectations are queued at issue, a negedge monitor pops and compares.
module tb_rtc_bus_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req, req_we;
   logic [23:0] req_addr, req_wdata;
   logic [2:0]  gnt, done;
   logic [7:0]  rdata;
   logic        busy;
   wire  [7:0]  DATA_ADDRESS;
   logic        ChipSelect, Read, Write, AoD;

   always #5 clk = ~clk;

   rtc_bus_sequencer dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
      .DATA_ADDRESS(DATA_ADDRESS), .ChipSelect(ChipSelect), .Read(Read),
      .Write(Write), .AoD(AoD)
   );

   // RTC chip model: answers reads during the data phase.
   logic       mdl_rd = 1'b0;
   logic [7:0] mdl_dat = 8'h37;
   assign DATA_ADDRESS = (!ChipSelect && AoD && mdl_rd) ? mdl_dat : 8'bzzzz_zzzz;

   typedef struct { int idx; int gap; bit rd; } gnt_exp_t;
   typedef struct { int idx; logic [7:0] dat; } done_exp_t;
   typedef struct { bit aod; bit rd; logic [7:0] val; } stb_exp_t;

   gnt_exp_t  gq[$];
   done_exp_t dq[$];
   stb_exp_t  sq[$];

   int         pass_cnt = 0, total_cnt = 0;
   logic [7:0] last_rd = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic issue(input int idx, input bit we, input logic [7:0] addr,
                        input logic [7:0] wd, input int gap, input bit complete);
      req_we[idx]           = we;
      req_addr[8*idx +: 8]  = addr;
      req_wdata[8*idx +: 8] = wd;
      gq.push_back('{idx, gap, !we});
      sq.push_back('{1'b0, 1'b0, addr});
      if (complete) begin
         if (!we) last_rd = mdl_dat;
         sq.push_back('{1'b1, !we, we ? wd : mdl_dat});
         dq.push_back('{idx, last_rd});
      end
   endtask

   // Monitor state
   int         cyc = 0, g_cyc = 0, f_cyc = 0, run = 0, done_cnt = 0;
   logic [2:0] gnt_prev = 3'b000;
   bit         run_aod, run_rd, both_low = 1'b0;
   logic [7:0] run_val;
   gnt_exp_t   ge;
   done_exp_t  de;
   stb_exp_t   se;

   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         run      = 0;
         gnt_prev = 3'b000;
         mdl_rd   = 1'b0;
      end else begin
         if (!Read && !Write) both_low = 1'b1;
         if (gnt != 3'b000 && gnt_prev == 3'b000) begin
            g_cyc = cyc;
            if (gq.size() == 0) chk("unexpected_gnt", {29'd0, gnt}, 32'd0);
            else begin
               ge = gq.pop_front();
               mdl_rd = ge.rd;
               chk("gnt", {29'd0, gnt}, 32'd1 << ge.idx);
               if (ge.gap > 0) chk("gnt_gap", cyc - f_cyc, ge.gap);
            end
         end
         if (gnt == 3'b000 && gnt_prev != 3'b000) f_cyc = cyc;
         gnt_prev = gnt;
         if (done != 3'b000) begin
            done_cnt++;
            if (dq.size() == 0) chk("unexpected_done", {29'd0, done}, 32'd0);
            else begin
               de = dq.pop_front();
               chk("done", {29'd0, done}, 32'd1 << de.idx);
               chk("latency", cyc - g_cyc, 12);
               chk("rdata", {24'd0, rdata}, {24'd0, de.dat});
            end
         end
         if (!ChipSelect && (!Write || !Read)) begin
            if (run == 0) begin
               run_aod = AoD;
               run_rd  = !Read;
               run_val = DATA_ADDRESS;
            end
            run++;
         end else if (run > 0) begin
            if (sq.size() == 0) chk("unexpected_strobe", run, 0);
            else begin
               se = sq.pop_front();
               chk("strobe_aod", {31'd0, run_aod}, {31'd0, se.aod});
               chk("strobe_kind", {31'd0, run_rd}, {31'd0, se.rd});
               chk("strobe_bus", {24'd0, run_val}, {24'd0, se.val});
               chk("strobe_len", run, 4);
            end
            run = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_dones(input int target, input string name);
      for (int i = 0; i < 400 && done_cnt < target; i++) tick();
      if (done_cnt < target) chk(name, done_cnt, target);
   endtask

   int bad;

   initial begin
      reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      #2 reset = 1'b0;
      #1;
      chk("rst_gnt", {29'd0, gnt}, 32'd0);
      chk("rst_done", {29'd0, done}, 32'd0);
      chk("rst_rdata", {24'd0, rdata}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_pins", {28'd0, ChipSelect, Read, Write, AoD}, 32'hF);
      repeat (3) tick();
      reset = 1'b1;

      // Idle for 20 cycles with no requests
      bad = 0;
      repeat (20) begin
         tick();
         if (!(ChipSelect && Read && Write && AoD) || busy) bad++;
      end
      chk("idle_pins", bad, 0);

      // Single write from requester 0
      mdl_dat = 8'h37;
      issue(0, 1'b1, 8'h21, 8'h45, 0, 1'b1);
      req = 3'b001;
      tick();
      chk("gnt_next_cycle", {29'd0, gnt}, 32'd1);
      wait_dones(1, "timeout_write");
      req = 3'b000;

      // Single read from requester 2
      repeat (4) tick();
      issue(2, 1'b0, 8'h22, 8'h00, 0, 1'b1);
      req = 3'b100;
      wait_dones(2, "timeout_read");
      req = 3'b000;

      // All three held: round-robin 0,1,2,0,1,2 back to back
      repeat (4) tick();
      mdl_dat = 8'hA5;
      issue(0, 1'b1, 8'h01, 8'h10, 0, 1'b1);
      issue(1, 1'b0, 8'h11, 8'h00, 3, 1'b1);
      issue(2, 1'b1, 8'h21, 8'h12, 3, 1'b1);
      issue(0, 1'b1, 8'h01, 8'h10, 3, 1'b1);
      issue(1, 1'b0, 8'h11, 8'h00, 3, 1'b1);
      issue(2, 1'b1, 8'h21, 8'h12, 3, 1'b1);
      req = 3'b111;
      wait_dones(8, "timeout_rr");
      req = 3'b000;

      // Reset during the data strobe
      repeat (4) tick();
      issue(0, 1'b1, 8'h30, 8'h55, 0, 1'b0);
      req = 3'b001;
      for (int i = 0; i < 100 && !(!ChipSelect && AoD && !Write); i++) @(negedge clk);
      chk("reach_d_strb", {29'd0, ChipSelect, AoD, Write}, 32'b010);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_pins", {28'd0, ChipSelect, Read, Write, AoD}, 32'hF);
      chk("midrst_gnt", {29'd0, gnt}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_rdata", {24'd0, rdata}, 32'd0);
      req = 3'b000;
      last_rd = 8'h00;
      repeat (3) tick();
      reset = 1'b1;
      repeat (2) tick();
      mdl_dat = 8'h5A;
      issue(1, 1'b0, 8'h40, 8'h00, 0, 1'b1);
      req = 3'b010;
      wait_dones(9, "timeout_after_rst");
      req = 3'b000;

      // Requester 1 drops req during the address strobe
      repeat (4) tick();
      issue(1, 1'b1, 8'h66, 8'h77, 0, 1'b1);
      req = 3'b010;
      for (int i = 0; i < 100 && !(!ChipSelect && !AoD && !Write); i++) @(negedge clk);
      tick();
      req = 3'b000;
      wait_dones(10, "timeout_drop");
      repeat (30) tick();

      chk("end_busy", {31'd0, busy}, 32'd0);
      chk("rw_both_low", {31'd0, both_low}, 32'd0);
      chk("gq_empty", gq.size(), 0);
      chk("dq_empty", dq.size(), 0);
      chk("sq_empty", sq.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
